// File: rtl/nway_cache_pkg.sv
// Shared types and sizing helpers for the N-way write-back cache.
// Also holds the line address builder used by the WB and FILL states.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    WB   = 2'd2,
    FILL = 2'd3
  } cache_state_t;

  function automatic int s_tag(input int off, input int idx);
    return 32 - off - idx;
  endfunction

  function automatic int s_line(input int off);
    return 8 * (2 ** off);
  endfunction

  function automatic int plru_bits(input int ways);
    return ways - 1;
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] index,
                                            input int off, input int idx);
    return (tag << (off + idx)) | (index << off);
  endfunction

endpackage

// File: rtl/nway_cache_if.sv
// CPU-side and physical-memory-side signals of the cache.
// slave is the cache view; master is the CPU/memory (bench) view.
interface nway_cache_if #(
  parameter int s_line = 256
);
  logic [31:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [3:0]        mem_byte_enable;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/nway_cache_plru.sv
// Tree pseudo-LRU for one set: heap-ordered bits, node 1 is the root.
// Leaf for way w is node num_ways+w; a 0 bit steers the victim walk left.
module plru_tree #(
  parameter int num_ways = 4
) (
  input  logic [num_ways-1:1]         bits,
  input  logic [$clog2(num_ways)-1:0] way,
  output logic [$clog2(num_ways)-1:0] victim,
  output logic [num_ways-1:1]         next_bits
);
  localparam int LVL   = $clog2(num_ways);
  localparam int WAY_W = $clog2(num_ways);

  int vnode;
  int anode;

  always_comb begin
    vnode = 1;
    for (int l = 0; l < LVL; l++) vnode = 2 * vnode + int'(bits[vnode]);
    victim = WAY_W'(vnode - num_ways);
  end

  // Each ancestor of the accessed leaf points into the sibling subtree.
  always_comb begin
    next_bits = bits;
    anode     = num_ways + int'(way);
    for (int l = 0; l < LVL; l++) begin
      next_bits[anode / 2] = (anode % 2 == 0);
      anode = anode / 2;
    end
  end
endmodule

// File: rtl/nway_cache.sv
// N-way set-associative write-back, write-allocate cache with PLRU replacement.
// One request at a time: IDLE -> TAG -> (WB) -> FILL -> TAG.
module nway_cache
  import cache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4
) (
  input logic         clk,
  input logic         rst,
  nway_cache_if.slave bus
);
  localparam int TAG_W    = s_tag(s_offset, s_index);
  localparam int LINE_W   = s_line(s_offset);
  localparam int NUM_SETS = 2 ** s_index;
  localparam int WAY_W    = $clog2(num_ways);
  localparam int BYTES    = LINE_W / 8;
  localparam int NODES    = plru_bits(num_ways);

  cache_state_t state_q, state_d;
  logic [NUM_SETS-1:0][num_ways-1:0]            valid_q, valid_d, dirty_q, dirty_d;
  logic [NUM_SETS-1:0][num_ways-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [NUM_SETS-1:0][NODES:1]                 plru_q, plru_d;
  logic [WAY_W-1:0]                             victim_q, victim_d;
  logic [LINE_W-1:0]                            data_q [NUM_SETS][num_ways];

  logic [TAG_W-1:0]      req_tag;
  logic [s_index-1:0]    req_idx;
  logic [s_offset-3:0]   req_word;
  logic [num_ways-1:0]   hit_vec;
  logic                  hit, inv_found;
  logic [WAY_W-1:0]      hit_way, inv_way, plru_victim, victim_sel;
  logic [NODES:1]        plru_next;
  logic [LINE_W-1:0]     hit_line, victim_line;

  logic                  data_we;
  logic [WAY_W-1:0]      data_way;
  logic [BYTES-1:0]      data_wbe;
  logic [LINE_W-1:0]     data_wdata;

  logic [31:0]           rdata, paddr;
  logic                  resp, pread, pwrite;
  logic [LINE_W-1:0]     pwdata;

  assign req_tag  = bus.mem_address[31 -: TAG_W];
  assign req_idx  = bus.mem_address[s_offset +: s_index];
  assign req_word = bus.mem_address[2 +: s_offset-2];

  // Fills always land in the latched victim, so at most one way can match.
  always_comb begin
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < num_ways; w++) begin
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      if (hit_vec[w]) hit_way = hit_way | WAY_W'(w);
    end
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign hit         = |hit_vec;
  assign victim_sel  = inv_found ? inv_way : plru_victim;
  assign hit_line    = data_q[req_idx][hit_way];
  assign victim_line = data_q[req_idx][victim_q];

  plru_tree #(.num_ways(num_ways)) u_plru (
    .bits      (plru_q[req_idx]),
    .way       (hit_way),
    .victim    (plru_victim),
    .next_bits (plru_next)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    plru_d     = plru_q;
    victim_d   = victim_q;
    rdata      = '0;
    resp       = 1'b0;
    paddr      = '0;
    pread      = 1'b0;
    pwrite     = 1'b0;
    pwdata     = '0;
    data_we    = 1'b0;
    data_way   = hit_way;
    data_wbe   = '0;
    data_wdata = '0;
    case (state_q)
      IDLE: if (bus.mem_read || bus.mem_write) state_d = TAG;
      TAG: begin
        if (hit) begin
          resp            = 1'b1;
          rdata           = hit_line[{req_word, 5'b0} +: 32];
          plru_d[req_idx] = plru_next;
          state_d         = IDLE;
          if (bus.mem_write) begin
            dirty_d[req_idx][hit_way]      = 1'b1;
            data_we                        = 1'b1;
            data_wbe[{req_word, 2'b0} +: 4] = bus.mem_byte_enable;
            data_wdata                     = {(LINE_W/32){bus.mem_wdata}};
          end
        end else begin
          victim_d = victim_sel;
          state_d  = (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) ? WB : FILL;
        end
      end
      WB: begin
        pwrite = 1'b1;
        paddr  = line_addr(32'(tag_q[req_idx][victim_q]), 32'(req_idx), s_offset, s_index);
        pwdata = victim_line;
        if (bus.pmem_resp) begin
          dirty_d[req_idx][victim_q] = 1'b0;
          state_d                    = FILL;
        end
      end
      FILL: begin
        pread = 1'b1;
        paddr = line_addr(32'(req_tag), 32'(req_idx), s_offset, s_index);
        if (bus.pmem_resp) begin
          data_we                    = 1'b1;
          data_way                   = victim_q;
          data_wbe                   = '1;
          data_wdata                 = bus.pmem_rdata;
          valid_d[req_idx][victim_q] = 1'b1;
          dirty_d[req_idx][victim_q] = 1'b0;
          tag_d[req_idx][victim_q]   = req_tag;
          state_d                    = TAG;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      plru_q   <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      plru_q   <= plru_d;
      victim_q <= victim_d;
    end
  end

  always_ff @(posedge clk) tag_q <= tag_d;

  always_ff @(posedge clk) begin
    if (data_we && !rst)
      for (int b = 0; b < BYTES; b++)
        if (data_wbe[b]) data_q[req_idx][data_way][b*8 +: 8] <= data_wdata[b*8 +: 8];
  end

  assign bus.mem_rdata    = rdata;
  assign bus.mem_resp     = resp;
  assign bus.pmem_address = paddr;
  assign bus.pmem_read    = pread;
  assign bus.pmem_write   = pwrite;
  assign bus.pmem_wdata   = pwdata;
endmodule

// File: tb/tb_nway_cache.sv
// Random + directed bench for nway_cache against a flat-memory / set-model reference.
module tb_nway_cache;
  localparam int OFF   = 5;
  localparam int IDX   = 3;
  localparam int WAYS  = 4;
  localparam int LINE  = 8 * (2 ** OFF);
  localparam int NSETS = 2 ** IDX;
  localparam int LVL   = $clog2(WAYS);
  localparam int WPL   = LINE / 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nway_cache_if #(.s_line(LINE)) bus ();
  nway_cache #(.s_offset(OFF), .s_index(IDX), .num_ways(WAYS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural memory: committed lines plus word overrides from CPU writes.
  logic [31:0]     gold   [int unsigned];
  logic [LINE-1:0] pstore [int unsigned];
  bit              m_valid [NSETS][WAYS];
  bit              m_dirty [NSETS][WAYS];
  int unsigned     m_tag   [NSETS][WAYS];
  bit              m_plru  [NSETS][WAYS];

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [LINE-1:0] line_of(input int unsigned la);
    logic [LINE-1:0] l;
    if (pstore.exists(la)) return pstore[la];
    for (int i = 0; i < WPL; i++) l[i*32 +: 32] = init_word((la << OFF) + 4 * i);
    return l;
  endfunction

  function automatic logic [31:0] gword(input int unsigned a);
    logic [LINE-1:0] l;
    if (gold.exists(a >> 2)) return gold[a >> 2];
    l = line_of(a >> OFF);
    return l[((a >> 2) % WPL) * 32 +: 32];
  endfunction

  function automatic logic [LINE-1:0] gline(input int unsigned la);
    logic [LINE-1:0] l;
    for (int i = 0; i < WPL; i++) l[i*32 +: 32] = gword((la << OFF) + 4 * i);
    return l;
  endfunction

  function automatic int m_victim(input int s);
    int n;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    n = 1;
    for (int l = 0; l < LVL; l++) n = 2 * n + int'(m_plru[s][n]);
    return n - WAYS;
  endfunction

  task automatic m_touch(input int s, input int w);
    int n;
    n = WAYS + w;
    while (n > 1) begin
      m_plru[s][n / 2] = (n % 2 == 0);
      n = n / 2;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_plru[s][w]  = 0;
      end
    gold.delete();
  endtask

  // Physical memory responder with random latency.
  bit              auto_pmem = 1;
  bit              inject    = 0;
  int              rd_cnt, wr_cnt;
  bit              fill_after_wb;
  logic [31:0]     rd_addr, wb_addr;
  logic [LINE-1:0] wb_line;

  initial begin
    int d;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (inject) begin
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        inject = 0;
      end else if (auto_pmem && !rst && (bus.pmem_read || bus.pmem_write)) begin
        d = $urandom_range(0, 3);
        chk("pmem_excl", LINE'(bus.pmem_read & bus.pmem_write), LINE'(0));
        repeat (d) begin
          @(negedge clk);
          chk("pmem_hold", LINE'(bus.pmem_read | bus.pmem_write), LINE'(1));
        end
        if (bus.pmem_write) begin
          wr_cnt++;
          wb_addr = bus.pmem_address;
          wb_line = bus.pmem_wdata;
          chk("wb_line", bus.pmem_wdata, gline(bus.pmem_address >> OFF));
          pstore[bus.pmem_address >> OFF] = bus.pmem_wdata;
        end else begin
          rd_cnt++;
          rd_addr        = bus.pmem_address;
          fill_after_wb  = (wr_cnt > 0);
          bus.pmem_rdata = line_of(bus.pmem_address >> OFF);
        end
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
      end
    end
  end

  logic [31:0] last_rdata;
  int          last_cyc;

  // Starts and ends just after a rising edge with the cache in IDLE.
  task automatic access(input bit wr, input bit both, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    int s, way, v, cyc;
    int unsigned tg;
    bit hit, wb, resp;
    logic [31:0] exp_rd, merged, wbexp;
    s   = int'((a >> OFF) % NSETS);
    tg  = a >> (OFF + IDX);
    hit = 0; way = 0; wb = 0; wbexp = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tg) begin hit = 1; way = w; end
    if (!hit) begin
      v     = m_victim(s);
      wb    = m_valid[s][v] && m_dirty[s][v];
      wbexp = (32'(m_tag[s][v]) << (OFF + IDX)) | (32'(s) << OFF);
      way   = v;
    end
    exp_rd = gword(a);
    rd_cnt = 0; wr_cnt = 0; fill_after_wb = 0;
    bus.mem_address     = a;
    bus.mem_read        = !wr || both;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    cyc = 0; resp = 0; last_rdata = '0;
    while (!resp && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_resp) begin resp = 1; last_rdata = bus.mem_rdata; end
    end
    last_cyc = cyc;
    chk("resp_seen", LINE'(resp), LINE'(1));
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (!wr) chk("rdata", LINE'(last_rdata), LINE'(exp_rd));
    chk("fill_cnt", LINE'(rd_cnt), LINE'(hit ? 0 : 1));
    if (!hit) chk("fill_addr", LINE'(rd_addr), LINE'({a[31:OFF], {OFF{1'b0}}}));
    chk("wb_cnt", LINE'(wr_cnt), LINE'(wb ? 1 : 0));
    if (wb) begin
      chk("wb_addr", LINE'(wb_addr), LINE'(wbexp));
      chk("wb_first", LINE'(fill_after_wb), LINE'(1));
    end
    if (hit) chk("hit_cycles", LINE'(cyc), LINE'(2));
    if (!hit) begin
      m_valid[s][way] = 1;
      m_dirty[s][way] = 0;
      m_tag[s][way]   = tg;
    end
    m_touch(s, way);
    if (wr) begin
      merged = exp_rd;
      for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
      gold[a >> 2]    = merged;
      m_dirty[s][way] = 1;
    end
  endtask

  task automatic quiet_chk(input string tag);
    chk({tag, "_resp"},  LINE'(bus.mem_resp),     LINE'(0));
    chk({tag, "_pread"}, LINE'(bus.pmem_read),    LINE'(0));
    chk({tag, "_pwr"},   LINE'(bus.pmem_write),   LINE'(0));
    chk({tag, "_rdata"}, LINE'(bus.mem_rdata),    LINE'(0));
    chk({tag, "_paddr"}, LINE'(bus.pmem_address), LINE'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE-1:0] l;
    logic [31:0] a;
    bit got;
    int cyc;
    bus.mem_address     = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;

    do_reset();
    @(negedge clk);
    quiet_chk("reset");
    @(posedge clk);
    #1;

    // Cold miss, hit, then byte-merged write hit
    l = line_of(32'h40 >> OFF);
    l[31:0] = 32'h11223344;
    pstore[32'h40 >> OFF] = l;
    access(0, 0, 32'h40, 4'h0, 32'h0);
    chk("cold_fill_addr", LINE'(rd_addr), LINE'(32'h40));
    chk("cold_rdata", LINE'(last_rdata), LINE'(32'h11223344));
    access(0, 0, 32'h44, 4'h0, 32'h0);
    chk("hit_latency", LINE'(last_cyc), LINE'(2));
    chk("hit_no_pmem", LINE'(rd_cnt + wr_cnt), LINE'(0));
    access(1, 0, 32'h40, 4'b0101, 32'hAABBCCDD);
    access(0, 0, 32'h40, 4'h0, 32'h0);
    chk("merge_rdata", LINE'(last_rdata), LINE'(32'h11BB33DD));
    chk("merge_no_pmem", LINE'(rd_cnt + wr_cnt), LINE'(0));

    // PLRU: A..D fill set 2, hit A, then E must displace C
    do_reset();
    for (int t = 0; t < 4; t++) access(0, 0, 32'(t) << 8 | 32'h40, 4'h0, 32'h0);
    access(0, 0, 32'h040, 4'h0, 32'h0);
    access(0, 0, 32'h440, 4'h0, 32'h0);
    chk("plru_e_miss", LINE'(rd_cnt), LINE'(1));
    access(0, 0, 32'h040, 4'h0, 32'h0);
    chk("plru_a_kept", LINE'(rd_cnt), LINE'(0));
    access(0, 0, 32'h140, 4'h0, 32'h0);
    chk("plru_b_kept", LINE'(rd_cnt), LINE'(0));
    access(0, 0, 32'h340, 4'h0, 32'h0);
    chk("plru_d_kept", LINE'(rd_cnt), LINE'(0));
    access(0, 0, 32'h240, 4'h0, 32'h0);
    chk("plru_c_evicted", LINE'(rd_cnt), LINE'(1));

    // Dirty way 0 becomes the victim after B, C, D are touched
    do_reset();
    access(1, 0, 32'h040, 4'hF, 32'hDEADBEEF);
    for (int t = 1; t < 4; t++) access(0, 0, 32'(t) << 8 | 32'h40, 4'h0, 32'h0);
    access(0, 0, 32'h440, 4'h0, 32'h0);
    chk("dirty_wb_cnt", LINE'(wr_cnt), LINE'(1));
    chk("dirty_wb_addr", LINE'(wb_addr), LINE'(32'h40));
    chk("dirty_wb_word0", LINE'(wb_line[31:0]), LINE'(32'hDEADBEEF));
    access(0, 0, 32'h040, 4'h0, 32'h0);
    chk("dirty_refill", LINE'(last_rdata), LINE'(32'hDEADBEEF));

    // Reset in the middle of a fill; a late pmem_resp must be ignored
    auto_pmem = 0;
    bus.mem_address = 32'h0000_1040;
    bus.mem_read    = 1'b1;
    got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = bus.pmem_read;
    end
    chk("fill_started", LINE'(got), LINE'(1));
    rst = 1'b1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    chk("rst_pread", LINE'(bus.pmem_read), LINE'(0));
    chk("rst_resp", LINE'(bus.mem_resp), LINE'(0));
    rst = 1'b0;
    inject = 1;
    cyc = 0;
    while (inject && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("late_resp_sent", LINE'(inject), LINE'(0));
    repeat (3) begin
      @(negedge clk);
      quiet_chk("late");
    end
    @(posedge clk);
    #1;
    model_reset();
    auto_pmem = 1;
    access(0, 0, 32'h040, 4'h0, 32'h0);
    chk("reread_miss", LINE'(rd_cnt), LINE'(1));

    // Random traffic over a few tags per set to force conflicts and writebacks
    for (int i = 0; i < 250; i++) begin
      a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 7)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 2) == 0)
        access(1, $urandom_range(0, 3) == 0, a, 4'($urandom), $urandom);
      else
        access(0, 0, a, 4'h0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
